noc_vc_input_buffer: RTL and testbench
======================================

NOC_VC_INPUT_BUFFER -- requirements
Module: noc_vc_input_buffer

Interface
REQ-001 Parameter FLIT_W, default 23, flit width: [22:7] payload, [6:3] address, [2:0] target.
REQ-002 Parameter DEPTH, default 9, flits per virtual channel (VC), legal range 2..64.
REQ-003 Parameter NUM_VC, default 2, number of VCs, legal range 1..8.
REQ-004 Derived: VC_W = max(1, clog2(NUM_VC)); CNT_W = clog2(DEPTH+1).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  write request for in_flit.
REQ-008 in_vc  input  VC_W  target VC of the write.
REQ-009 in_flit  input  FLIT_W  flit to write.
REQ-010 pop  input  NUM_VC  per-VC pop request for the head flit.
REQ-011 out_flit  output  NUM_VC*FLIT_W  head flit per VC; VC v occupies bits [v*FLIT_W +: FLIT_W].
REQ-012 out_valid  output  NUM_VC  per-VC head valid (VC non-empty, or bypass per REQ-029).
REQ-013 full  output  NUM_VC  per-VC count == DEPTH.
REQ-014 count  output  NUM_VC*CNT_W  per-VC occupancy.
REQ-015 credit  output  NUM_VC  one-cycle pulse per flit consumed from that VC.
REQ-016 err_overflow, err_underflow  output  1 each  sticky error flags.

Function
REQ-017 Each VC SHALL be an independent circular FIFO with read pointer, write pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-018 out_flit for VC v SHALL equal the stored entry at its read pointer, combinationally, with zero added latency; when empty it SHALL be all-zeros.
REQ-019 Write to a non-full VC: flit stored at write pointer, count +1 next cycle; flit visible at head one cycle after the write when VC was empty.
REQ-020 Pop of a non-empty VC: read pointer advances, count -1 next cycle, credit[v] pulses high in the following cycle.
REQ-021 Simultaneous write and pop on the same non-empty VC, including full: both take effect, count unchanged, no overflow.
REQ-022 Write to a full VC without pop of that VC: flit dropped, VC contents and count unchanged, err_overflow set.
REQ-023 Pop of an empty VC (outside bypass): ignored, no credit, err_underflow set.
REQ-024 Pops on several VCs in one cycle SHALL all be honoured independently; at most one write per cycle.
REQ-025 in_vc >= NUM_VC with in_valid: write dropped, err_overflow set.
REQ-026 Error flags SHALL remain set until reset; they never affect data flow.

Reset
REQ-027 On rst low, immediately: all pointers, counts, out_valid, full, credit, error flags = 0; out_flit = 0; storage contents need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all buffered flits; first write after release behaves as into an empty buffer.

Configuration
REQ-029 Macro NOC_IBUF_BYPASS_EN defined: when VC v is empty and in_valid targets v, out_valid[v] = 1 and out_flit for v = in_flit combinationally; pop[v] in that cycle consumes the flit without storing it, count stays 0, credit pulses next cycle, no underflow.
REQ-030 Macro not defined: no combinational in->out path; out_valid is purely registered state; an empty-VC pop is an underflow even with a same-cycle write, and the write is stored.

Structure
REQ-031 Package noc_pkg SHALL hold FLIT_W default, field offsets (PAYLOAD_LSB=7, ADDR_LSB=3, TARGET_LSB=0), and flit_t typedef.
REQ-032 One sub-module noc_vc_fifo (single-VC circular FIFO with count, full, empty, credit), instantiated NUM_VC times; top holds write demux and error flags.

Verification
REQ-033 Reset, write 0x1A5 to VC0, no pop -> next cycle out_valid=01, VC0 out_flit=0x1A5, count VC0=1.
REQ-034 DEPTH=9: write 10 flits to VC1 with no pop -> full[1]=1 after 9th, 10th dropped, err_overflow=1, pops return flits 1..9 in order.
REQ-035 VC1 full, write and pop VC1 same cycle -> count stays 9, no overflow, head advances, credit[1] pulses once.
REQ-036 Pop VC0 while empty, no write -> no state change, err_underflow=1, credit=00.
REQ-037 Bypass build: empty VC0, in_valid+pop[0] with 0x7FF -> out_flit VC0=0x7FF same cycle, count 0 after, credit[0] pulses; non-bypass build: flit stored, count=1, err_underflow=1.
REQ-038 VC0 holding 3 flits, assert rst low between clock edges -> all outputs 0 immediately; after release, write 0x3 -> head 0x3, count 1.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: flit format shared by the NoC VC input buffer and its users
package noc_pkg;
    localparam int FLIT_W      = 23;
    localparam int PAYLOAD_LSB = 7;
    localparam int ADDR_LSB    = 3;
    localparam int TARGET_LSB  = 0;
    typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: single-VC circular FIFO with occupancy, credit return and error strobes
// NOC_IBUF_BYPASS_EN: an empty FIFO forwards the incoming flit to its head in the same cycle
module noc_vc_fifo #(
    parameter int FLIT_W = 23,
    parameter int DEPTH  = 9,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              pop,
    output logic [FLIT_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              credit,
    output logic              ovf,
    output logic              unf
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic empty, rd_ok, wr_ok, byp_ok;
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction
    assign empty = count == '0;
    assign full  = count == CNT_W'(DEPTH);
    assign rd_ok = pop & ~empty;
`ifdef NOC_IBUF_BYPASS_EN
    // popping the forwarded flit consumes it without ever storing it
    assign byp_ok = pop & empty & wr;
    assign valid  = ~empty | wr;
    assign head   = ~empty ? mem[rd_ptr] : wr ? wr_data : '0;
`else
    assign byp_ok = 1'b0;
    assign valid  = ~empty;
    assign head   = empty ? '0 : mem[rd_ptr];
`endif
    // a full FIFO still accepts a write when its head leaves in the same cycle
    assign wr_ok = wr & (~full | pop) & ~byp_ok;
    assign ovf   = wr & full & ~pop;
    assign unf   = pop & empty & ~byp_ok;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            credit <= 1'b0;
        end else begin
            rd_ptr <= rd_ok ? nxt(rd_ptr) : rd_ptr;
            wr_ptr <= wr_ok ? nxt(wr_ptr) : wr_ptr;
            count  <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            credit <= rd_ok | byp_ok;
        end
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/noc_vc_input_buffer.sv
// noc_vc_input_buffer: per-VC flit input buffer with write demux, credit return and sticky errors
// NOC_IBUF_BYPASS_EN: enables same-cycle forwarding into empty VCs (see noc_vc_fifo)
module noc_vc_input_buffer #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 9,
    parameter int NUM_VC = 2,
    parameter int VC_W   = NUM_VC > 1 ? $clog2(NUM_VC) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [VC_W-1:0]         in_vc,
    input  logic [FLIT_W-1:0]       in_flit,
    input  logic [NUM_VC-1:0]       pop,
    output logic [NUM_VC*FLIT_W-1:0] out_flit,
    output logic [NUM_VC-1:0]       out_valid,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic [NUM_VC-1:0]       credit,
    output logic                    err_overflow,
    output logic                    err_underflow
);
    logic [NUM_VC-1:0] wr, ovf, unf;
    logic bad_vc;
    assign bad_vc = in_valid & ({1'b0, in_vc} >= (VC_W + 1)'(NUM_VC));
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        // gated by rst so a bypassed flit cannot reach the head while in reset
        assign wr[v] = rst & in_valid & (in_vc == VC_W'(v));
        noc_vc_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr[v]),
            .wr_data(in_flit),
            .pop    (pop[v]),
            .head   (out_flit[v*FLIT_W +: FLIT_W]),
            .valid  (out_valid[v]),
            .full   (full[v]),
            .count  (count[v*CNT_W +: CNT_W]),
            .credit (credit[v]),
            .ovf    (ovf[v]),
            .unf    (unf[v])
        );
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= err_overflow | bad_vc | (|ovf);
            err_underflow <= err_underflow | (|unf);
        end
endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// tb_noc_vc_input_buffer: directed and random checks against a queue-based reference model
module tb_noc_vc_input_buffer;
    import noc_pkg::*;
    localparam int D  = 9;
    localparam int N  = 2;
    localparam int CW = $clog2(D + 1);
`ifdef NOC_IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
    logic [0:0] in_vc = '0;
    flit_t in_flit = '0;
    logic [N-1:0] pop = '0;
    logic [N*FLIT_W-1:0] out_flit;
    logic [N-1:0] out_valid, full, credit;
    logic [N*CW-1:0] count;
    logic err_overflow, err_underflow;
    flit_t q [N][$];
    logic [N-1:0] m_cr = '0;
    logic m_ovf = 1'b0, m_unf = 1'b0;
    int total = 0, bad = 0;

    noc_vc_input_buffer #(.DEPTH(D), .NUM_VC(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .pop(pop), .out_flit(out_flit), .out_valid(out_valid), .full(full),
        .count(count), .credit(credit), .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N*FLIT_W-1:0] ef;
        logic [N-1:0] ev, efu;
        logic [N*CW-1:0] ec;
        bit byp;
        ef = '0; ev = '0; efu = '0; ec = '0;
        for (int v = 0; v < N; v++) begin
            byp = BYP && rst && in_valid && int'(in_vc) == v && q[v].size() == 0;
            ev[v] = q[v].size() > 0 || byp;
            ef[v*FLIT_W +: FLIT_W] = q[v].size() > 0 ? q[v][0] : byp ? in_flit : '0;
            ec[v*CW +: CW] = CW'(q[v].size());
            efu[v] = q[v].size() == D;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, "_flit"}, 64'(out_flit), 64'(ef));
        chk({tag, "_count"}, 64'(count), 64'(ec));
        chk({tag, "_full"}, 64'(full), 64'(efu));
        chk({tag, "_credit"}, 64'(credit), 64'(m_cr));
        chk({tag, "_ovf"}, 64'(err_overflow), 64'(m_ovf));
        chk({tag, "_unf"}, 64'(err_underflow), 64'(m_unf));
    endtask

    // pops are applied before the write, so a full VC that pops can also accept
    task automatic model_step();
        bit taken;
        int tv;
        taken = !in_valid;
        tv = int'(in_vc);
        m_cr = '0;
        for (int v = 0; v < N; v++)
            if (pop[v]) begin
                if (q[v].size() > 0) begin
                    void'(q[v].pop_front());
                    m_cr[v] = 1'b1;
                end else if (BYP && in_valid && tv == v) begin
                    taken = 1'b1;
                    m_cr[v] = 1'b1;
                end else m_unf = 1'b1;
            end
        if (!taken) begin
            if (tv >= N || q[tv].size() >= D) m_ovf = 1'b1;
            else q[tv].push_back(in_flit);
        end
    endtask

    task automatic step(input logic iv, input int vc, input flit_t f, input logic [N-1:0] p, input string tag);
        @(negedge clk);
        in_valid = iv;
        in_vc = 1'(vc);
        in_flit = f;
        pop = p;
        #1 check_all(tag);
        model_step();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        in_valid = 1'b0;
        pop = '0;
        for (int v = 0; v < N; v++) q[v].delete();
        m_cr = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1 check_all(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int thr;
        logic [N-1:0] p;
        do_reset("rst");
        step(1'b1, 0, 23'h1A5, '0, "w0");
        step(1'b0, 0, '0, '0, "r33");
        chk("r33_head", 64'(out_flit[FLIT_W-1:0]), 64'h1A5);
        chk("r33_cnt", 64'(count[CW-1:0]), 64'd1);
        chk("r33_vld", 64'(out_valid), 64'b01);

        do_reset("rst34");
        for (int i = 1; i <= 10; i++) step(1'b1, 1, flit_t'(i), '0, "fill");
        step(1'b0, 0, '0, '0, "full");
        chk("r34_full", 64'(full[1]), 64'd1);
        chk("r34_ovf", 64'(err_overflow), 64'd1);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 0, '0, 2'b10, "drain");
            chk("r34_head", 64'(out_flit[FLIT_W +: FLIT_W]), 64'(i));
        end
        step(1'b0, 0, '0, '0, "drained");

        do_reset("rst35");
        for (int i = 1; i <= 9; i++) step(1'b1, 1, flit_t'(i + 16), '0, "refill");
        step(1'b1, 1, 23'h55, 2'b10, "wp");
        step(1'b0, 0, '0, '0, "r35");
        chk("r35_cnt", 64'(count[CW +: CW]), 64'd9);
        chk("r35_ovf", 64'(err_overflow), 64'd0);
        chk("r35_head", 64'(out_flit[FLIT_W +: FLIT_W]), 64'd18);
        chk("r35_cr", 64'(credit), 64'b10);
        step(1'b0, 0, '0, '0, "r35b");
        chk("r35_cr1", 64'(credit), 64'b00);

        do_reset("rst36");
        step(1'b0, 0, '0, 2'b01, "unf");
        step(1'b0, 0, '0, '0, "r36");
        chk("r36_unf", 64'(err_underflow), 64'd1);
        chk("r36_cr", 64'(credit), 64'b00);
        chk("r36_cnt", 64'(count), 64'd0);

        do_reset("rst37");
        step(1'b1, 0, 23'h7FF, 2'b01, "byp");
        step(1'b0, 0, '0, '0, "r37");
        chk("r37_cnt", 64'(count[CW-1:0]), BYP ? 64'd0 : 64'd1);
        chk("r37_unf", 64'(err_underflow), BYP ? 64'd0 : 64'd1);
        chk("r37_cr", 64'(credit[0]), BYP ? 64'd1 : 64'd0);

        do_reset("rst38");
        for (int i = 0; i < 3; i++) step(1'b1, 0, flit_t'(i + 40), '0, "pre38");
        do_reset("r38");
        step(1'b1, 0, 23'h3, '0, "w38");
        step(1'b0, 0, '0, '0, "r38b");
        chk("r38_head", 64'(out_flit[FLIT_W-1:0]), 64'h3);
        chk("r38_cnt", 64'(count[CW-1:0]), 64'd1);

        for (int c = 0; c < 3000; c++) begin
            if (c % 600 == 599) do_reset("rnd_rst");
            thr = (c / 150) % 2 ? 75 : 20;
            for (int v = 0; v < N; v++) p[v] = $urandom_range(0, 99) < thr;
            step(1'(($urandom_range(0, 99)) < 70), int'($urandom_range(0, N - 1)),
                 flit_t'($urandom), p, "rnd");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
